// File: rtl/mips_prog_loader_if.sv
// Host byte stream and pipeline memory write port of the program loader.
interface mips_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Host / testbench side: drives bytes, observes the handshake and the writes.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Byte-serial program loader: framed host bytes -> big-endian instruction
// words written to pipeline memory from address 0, then a start pulse, then
// wait for the processor to halt.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | hunt for the sync byte, other bytes dropped
// LEN_HI | receive high byte of the word count N
// LEN_LO | receive low byte of N and decide empty / too long / load
// BYTE   | receive 4 bytes of the next word, MSB first
// WRITE  | single memory write cycle, word_cnt advances
// START  | single cpu_start pulse
// RUN    | wait for cpu_halted
// ERR    | frame too long; swallow bytes until reset
module mips_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips_prog_loader_if.slave   host,
  output logic                cpu_start,
  input  logic                cpu_halted,
  output logic                busy,
  output logic                error,
  output logic [ADDR_W:0]     word_cnt
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, BYTE, WRITE, START, RUN, ERR
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [23:0]     shreg;
  logic [1:0]      byte_idx;
  logic            acc;
  logic [15:0]     len_rx;
  logic            len_too_big;
  logic [ADDR_W:0] cnt_inc;

  // in_ready is registered from the next state, so it always reflects the
  // current state and a byte is never taken in WRITE, START or RUN.
  assign acc         = host.in_valid & host.in_ready;
  assign len_rx      = {len_hi, host.in_data};
  assign len_too_big = 32'(len_rx) > (32'd1 << ADDR_W);
  assign cnt_inc     = word_cnt + {{ADDR_W{1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge clk1) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (acc && host.in_data == SYNC_BYTE) state_nxt = LEN_HI;
      LEN_HI: if (acc) state_nxt = LEN_LO;
      LEN_LO: begin
        if (acc) begin
          if (len_rx == 16'd0)  state_nxt = START;
          else if (len_too_big) state_nxt = ERR;
          else                  state_nxt = BYTE;
        end
      end
      BYTE:   if (acc && byte_idx == 2'd3) state_nxt = WRITE;
      WRITE:  state_nxt = (32'(cnt_inc) == 32'(len)) ? START : BYTE;
      START:  state_nxt = RUN;
      RUN:    if (cpu_halted) state_nxt = IDLE;
      ERR:    state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status/strobe outputs, decoded from the state being entered.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      host.in_ready <= 1'b1;
      host.mem_we   <= 1'b0;
      cpu_start     <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
    end else begin
      host.in_ready <= (state_nxt != WRITE) && (state_nxt != START) &&
                       (state_nxt != RUN);
      host.mem_we   <= (state_nxt == WRITE);
      cpu_start     <= (state_nxt == START);
      busy          <= (state_nxt != IDLE) && (state_nxt != ERR);
      error         <= (state_nxt == ERR);
    end
  end

  // Datapath: length capture, word assembly, write address/data, word count.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      len_hi         <= '0;
      len            <= '0;
      shreg          <= '0;
      byte_idx       <= '0;
      word_cnt       <= '0;
      host.mem_addr  <= '0;
      host.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE:   if (acc && host.in_data == SYNC_BYTE) word_cnt <= '0;
        LEN_HI: if (acc) len_hi <= host.in_data;
        LEN_LO: begin
          if (acc) begin
            len      <= len_rx;
            byte_idx <= '0;
          end
        end
        BYTE: begin
          if (acc) begin
            shreg    <= {shreg[15:0], host.in_data};
            byte_idx <= byte_idx + 2'd1;
            // Last byte: present the full word to memory in the WRITE cycle.
            if (byte_idx == 2'd3) begin
              host.mem_addr  <= word_cnt[ADDR_W-1:0];
              host.mem_wdata <= {shreg, host.in_data};
            end
          end
        end
        WRITE:  word_cnt <= cnt_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Byte-serial program loader upstream of mips32_pipeline.
- Receives a framed byte stream from a host link, assembles big-endian 32-bit instruction words and writes them into pipeline memory from word address 0 upward.
- After the last word it pulses a start strobe; the integration wrapper uses that strobe to clear HALTED and TAKEN_BRANCH and set PC to 0.
- It then waits for the processor to halt before accepting a new frame.

Parameters:
- ADDR_W, 10, memory word-address width; maximum program length is 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk1  in  1  single system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk1.
- in_data  in  8  host byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid & in_ready.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word.
- cpu_start  out  1  one-cycle pulse releasing the pipeline.
- cpu_halted  in  1  pipeline HALTED flag.
- busy  out  1  high in every state except IDLE and ERR.
- error  out  1  sticky until reset.
- word_cnt  out  ADDR_W+1  number of words written in the current frame.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - in_ready=1; mem_we=0; cpu_start=0; busy=0; error=0.
  - mem_addr=0; mem_wdata=0; word_cnt=0.
  - Reset has priority over everything. Mid-frame reset abandons the frame; no further mem_we is issued.
- All outputs are registered.
- States: IDLE, LEN_HI, LEN_LO, BYTE, WRITE, START, RUN, ERR.
- IDLE:
  - in_ready=1.
  - An accepted byte equal to SYNC_BYTE moves to LEN_HI and clears word_cnt.
  - Any other byte is discarded; state stays IDLE.
- LEN_HI / LEN_LO:
  - Accept the high byte, then the low byte, of a 16-bit word count N.
  - On the LEN_LO accept:
    - N=0 goes directly to START (empty program; memory untouched).
    - N>2**ADDR_W goes to ERR.
    - Otherwise go to BYTE with the byte index at 0.
- BYTE:
  - Accept 4 bytes MSB first into a 32-bit shift register.
  - After the 4th accept, go to WRITE. No byte is accepted in the same cycle the transition is taken.
- WRITE (exactly 1 cycle):
  - in_ready=0.
  - mem_we=1, mem_addr=word_cnt[ADDR_W-1:0], mem_wdata=assembled word.
  - word_cnt increments at the end of the cycle.
  - If the incremented word_cnt == N, go to START; otherwise go to BYTE.
- START (1 cycle): in_ready=0, cpu_start=1, then go to RUN.
- RUN:
  - in_ready=0.
  - When cpu_halted=1 is sampled, return to IDLE.
  - cpu_halted is ignored during the START cycle, because the pipeline clears HALTED in response to the pulse; RUN begins sampling on the next cycle.
- ERR: in_ready=1 with every byte silently dropped; error=1; leave only by reset.
- Latency:
  - 4th byte accepted at edge k gives mem_we high during cycle k+1.
  - The last write in cycle j gives cpu_start in cycle j+1.
- in_valid=0 stalls any receiving state indefinitely without side effects. in_data is only sampled on a transfer.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- mem_we and cpu_start are never high in the same cycle, and never high in IDLE, RUN or ERR.

Test Plan:
- Normal load:
  - Stimulus: A5 00 09, then words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with in_valid held high.
  - Required: 9 mem_we pulses at addresses 0..8 with exactly these data; word_cnt=9; one cpu_start pulse the cycle after the write to address 8.
  - Then: cpu_halted=1 for one cycle returns the loader to IDLE with busy=0.
- Backpressure and gaps:
  - Stimulus: same frame with in_valid toggled randomly.
  - Required: identical write sequence; no byte accepted while in_ready=0 (WRITE/START/RUN); no duplicated or lost bytes.
- Framing:
  - Stimulus: bytes 00 FF 12, then A5 00 01 DE AD BE EF.
  - Required: the first three bytes are dropped; a single write of deadbeef to address 0; one cpu_start.
- Boundaries:
  - Stimulus N=0: cpu_start fires 1 cycle after the LEN_LO accept and no mem_we.
  - Stimulus ADDR_W=4 with N=17: error=1, state ERR, no writes, no start.
  - Stimulus ADDR_W=4 with N=16: the last write goes to address 15.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after 2 bytes of word 3.
  - Required: all outputs return to their reset values at the next edge; no further mem_we. A subsequent full frame loads correctly from address 0.
- Halt handling:
  - Stimulus: cpu_halted held at 1 before and during START.
  - Required: the loader still enters RUN and returns to IDLE on the first RUN cycle; bytes sent during START/RUN are not accepted.
